cnt_slot_sched: RTL

Round-robin scheduler that shares one slot counter among `NREQ` requesters and grants exclusive use for a programmable number of cycles. It sits in front of the counter datapath and serialises access to it, so only one client at a time sees the running count. It reports completion or abort of every slot.

---
 rtl/cnt_slot_sched_pkg.sv | 7 +
 rtl/cnt_slot_sched_rr_pick.sv | 23 ++
 rtl/cnt_slot_sched.sv | 60 ++++++
 3 files changed

// File: rtl/cnt_slot_sched_pkg.sv
// cnt_slot_sched_pkg: shared state encoding and default sizes for the slot scheduler
package cnt_slot_sched_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, GAP = 2'd2} state_t;
  localparam int DEF_NREQ = 4;
  localparam int DEF_CW = 5;
  localparam int DEF_IW = 2;
endpackage

// File: rtl/cnt_slot_sched_rr_pick.sv
// rr_pick: combinational round-robin picker searching from ptr upward with wrap
module rr_pick
  import cnt_slot_sched_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IW = DEF_IW
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   winner,
  output logic            any
);
  always_comb begin
    winner = '0;
    any = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[IW'((int'(ptr) + i) % NREQ)]) begin
        winner = IW'((int'(ptr) + i) % NREQ);
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/cnt_slot_sched.sv
// cnt_slot_sched: round-robin owner of a shared slot counter with done/abort reporting
module cnt_slot_sched
  import cnt_slot_sched_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int CW = DEF_CW,
  parameter int IW = DEF_IW
) (
  input  logic            clk,
  input  logic            rst_,
  input  logic [NREQ-1:0] req,
  input  logic [CW-1:0]   len,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   owner,
  output logic            busy,
  output logic [CW-1:0]   cnt,
  output logic            done,
  output logic            abort
);
  state_t state;
  logic [CW-1:0] len_q;
  logic [IW-1:0] ptr, w;
  logic any, own_req;
  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (.req(req), .ptr(ptr), .winner(w), .any(any));
  assign own_req = req[owner];
  assign done = state == HOLD && own_req && cnt == len_q - CW'(1);
  assign abort = state == HOLD && !own_req;
  always_ff @(posedge clk) begin
    if (!rst_) begin
      state <= IDLE;
      gnt <= '0;
      owner <= '0;
      busy <= 1'b0;
      cnt <= '0;
      len_q <= '0;
      ptr <= '0;
    end else begin
      case (state)
        IDLE: if (any) begin
          gnt <= NREQ'(1) << w;
          owner <= w;
          busy <= 1'b1;
          cnt <= '0;
          len_q <= (len == '0) ? CW'(1) : len;
          ptr <= (w == IW'(NREQ - 1)) ? '0 : w + IW'(1);
          state <= HOLD;
        end
        HOLD: if (done || abort) begin
          gnt <= '0;
          busy <= 1'b0;
          cnt <= '0;
          state <= GAP;
        end else begin
          cnt <= cnt + CW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
